// File: rtl/gomoku_pkg.sv
// Shared gomoku board constants, direction/state enums and position helpers.
// Used by the win checker, computer_player and the board controller.
package gomoku_pkg;

  localparam int BOARD_DIM = 10;
  localparam int CELLS     = BOARD_DIM * BOARD_DIM;
  localparam int POS_W     = 7;
  localparam int WIN_LEN   = 5;
  localparam int SPAN      = 5;
  localparam int WINDOW    = 2 * SPAN + 1;

  typedef enum logic [1:0] {
    DIR_H = 2'd0,
    DIR_V = 2'd1,
    DIR_D = 2'd2,
    DIR_A = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] pos_row(input logic [POS_W-1:0] p);
    return 4'(p / 7'(BOARD_DIM));
  endfunction

  function automatic logic [3:0] pos_col(input logic [POS_W-1:0] p);
    return 4'(p % 7'(BOARD_DIM));
  endfunction

endpackage

// File: rtl/cell_stepper.sv
// Combinational cell addressing: (r0, c0, dir, k) -> board index and on-board flag.
// Bounds are checked on row and column separately so lines never wrap.
module cell_stepper
  import gomoku_pkg::*;
(
  input  logic [3:0]       r0,
  input  logic [3:0]       c0,
  input  logic [1:0]       dir,
  input  logic signed [3:0] k,
  output logic [POS_W-1:0] idx,
  output logic             on_board
);

  logic signed [5:0] k_s;
  logic signed [5:0] r0_s;
  logic signed [5:0] c0_s;
  logic signed [5:0] r_s;
  logic signed [5:0] c_s;

  assign k_s  = {{2{k[3]}}, k};
  assign r0_s = $signed({2'b00, r0});
  assign c0_s = $signed({2'b00, c0});

  always_comb begin
    r_s = r0_s;
    c_s = c0_s;
    case (dir)
      DIR_H: c_s = c0_s + k_s;
      DIR_V: r_s = r0_s + k_s;
      DIR_D: begin
        r_s = r0_s + k_s;
        c_s = c0_s + k_s;
      end
      default: begin
        r_s = r0_s + k_s;
        c_s = c0_s - k_s;
      end
    endcase
  end

  assign on_board = (r_s >= 6'sd0) && (r_s < 6'sd10) && (c_s >= 6'sd0) && (c_s < 6'sd10);
  assign idx = on_board ? (7'(r_s[3:0]) * 7'd10 + 7'(c_s[3:0])) : 7'd0;

endmodule

// File: rtl/five_in_row_checker.sv
// Sequential five-in-a-row detector: scans 4 directions through pos, one cell per clock.
// Build option OVERLINE_EXCLUDE_EN: only runs of exactly WIN_LEN win (renju overline rule).
module five_in_row_checker
  import gomoku_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [POS_W-1:0] pos,
  input  logic [CELLS-1:0] board,
  output logic             busy,
  output logic             done,
  output logic             win,
  output logic [1:0]       win_dir,
  output logic [3:0]       run_len,
  output logic             err
);

  state_e           state;
  dir_e             dir_q;
  logic [3:0]       k_q;
  logic [3:0]       run_q;
  logic             rec_q;
  logic [3:0]       r0_q;
  logic [3:0]       c0_q;
  logic [CELLS-1:0] board_q;

  logic signed [3:0] k_off;
  logic [POS_W-1:0]  cell_idx;
  logic              cell_on;
  logic              stone;
  logic [3:0]        new_run;
  logic [3:0]        rec_len;
  logic              rec_now;
  logic              rec_wins;
  logic              bad_req;

  assign k_off = $signed(k_q - 4'(SPAN));

  cell_stepper u_step (
    .r0       (r0_q),
    .c0       (c0_q),
    .dir      (dir_q),
    .k        (k_off),
    .idx      (cell_idx),
    .on_board (cell_on)
  );

  assign stone   = cell_on && board_q[cell_idx];
  assign new_run = stone ? run_q + 4'd1 : 4'd0;
  // The run holding the centre ends at the first empty past k=0, or at the window edge.
  assign rec_now = !rec_q && ((!stone && (k_q > 4'(SPAN))) || (k_q == 4'(2 * SPAN)));
  assign rec_len = stone ? new_run : run_q;

`ifdef OVERLINE_EXCLUDE_EN
  assign rec_wins = (rec_len == 4'(WIN_LEN));
`else
  assign rec_wins = (rec_len >= 4'(WIN_LEN));
`endif

  assign bad_req = (pos >= 7'(CELLS)) || !board[pos];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      dir_q   <= DIR_H;
      k_q     <= '0;
      run_q   <= '0;
      rec_q   <= 1'b0;
      r0_q    <= '0;
      c0_q    <= '0;
      board_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      win     <= 1'b0;
      win_dir <= '0;
      run_len <= '0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            r0_q    <= pos_row(pos);
            c0_q    <= pos_col(pos);
            board_q <= board;
            dir_q   <= DIR_H;
            k_q     <= '0;
            run_q   <= '0;
            rec_q   <= 1'b0;
            win     <= 1'b0;
            win_dir <= '0;
            run_len <= '0;
            err     <= 1'b0;
            if (bad_req) begin
              err   <= 1'b1;
              state <= ST_DONE;
            end else begin
              busy  <= 1'b1;
              state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          run_q <= new_run;
          if (rec_now) begin
            rec_q <= 1'b1;
            if (rec_len > run_len) run_len <= rec_len;
            if (rec_wins && !win) begin
              win     <= 1'b1;
              win_dir <= dir_q;
            end
          end
          if (k_q == 4'(2 * SPAN)) begin
            k_q   <= '0;
            run_q <= '0;
            rec_q <= 1'b0;
            if (dir_q == DIR_A) state <= ST_DONE;
            else dir_q <= dir_e'(dir_q + 2'd1);
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_five_in_row_checker.sv
// Directed self-checking bench for five_in_row_checker with hand-computed expectations.
module tb_five_in_row_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  pos = '0;
  logic [99:0] board = '0;
  logic        busy;
  logic        done;
  logic        win;
  logic [1:0]  win_dir;
  logic [3:0]  run_len;
  logic        err;

  int total = 0;
  int bad = 0;
  int lat;
  int pulses;
  logic [99:0] b1, b2, b3, b4, b5, b6;

  always #5 clk = ~clk;

  five_in_row_checker dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pos     (pos),
    .board   (board),
    .busy    (busy),
    .done    (done),
    .win     (win),
    .win_dir (win_dir),
    .run_len (run_len),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulses start for one cycle, then counts clocks after the start edge until done.
  task automatic run_req(input logic [99:0] b, input logic [6:0] p, output int n);
    @(negedge clk);
    board = b;
    pos   = p;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic chk_result(input string tag, input int n, input int exp_lat, input logic exp_win,
                            input logic [1:0] exp_dir, input logic [3:0] exp_len, input logic exp_err);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_win"}, 32'(win), 32'(exp_win));
    if (exp_win) chk({tag, "_dir"}, 32'(win_dir), 32'(exp_dir));
    chk({tag, "_len"}, 32'(run_len), 32'(exp_len));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1 chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    b1 = '0; b1[30] = 1; b1[31] = 1; b1[32] = 1; b1[33] = 1; b1[34] = 1;
    b2 = '0; b2[27] = 1; b2[28] = 1; b2[29] = 1; b2[30] = 1; b2[31] = 1;
    b3 = '0; b3[4] = 1; b3[13] = 1; b3[22] = 1; b3[31] = 1; b3[40] = 1;
    b4 = '0; b4[5] = 1; b4[15] = 1; b4[25] = 1; b4[35] = 1; b4[45] = 1; b4[55] = 1;
    // plus-shape: row 5 and column 5 both win through 55; horizontal must be reported
    b5 = '0;
    for (int i = 0; i < 5; i++) begin
      b5[53 + i] = 1;
      b5[35 + 10 * i] = 1;
    end
    // run of five not through pos 36, which is isolated
    b6 = b1; b6[36] = 1;

    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_win", 32'(win), 0);
    chk("rst_dir", 32'(win_dir), 0);
    chk("rst_len", 32'(run_len), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    board = b1; pos = 7'd34; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t1_busy_rise", 32'(busy), 1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk_result("t1", lat, 45, 1, 2'd0, 4'd5, 0);
    repeat (3) @(posedge clk);
    #1 chk("t1_win_held", 32'(win), 1);

    @(negedge clk);
    board = b2; pos = 7'd29; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t2_win_cleared", 32'(win), 0);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk_result("t2_wrap", lat, 45, 0, 2'd0, 4'd3, 0);

    run_req(b3, 7'd22, lat);
    chk_result("t3_anti", lat, 45, 1, 2'd3, 4'd5, 0);

    run_req(b4, 7'd25, lat);
`ifdef OVERLINE_EXCLUDE_EN
    chk_result("t4_over", lat, 45, 0, 2'd1, 4'd6, 0);
`else
    chk_result("t4_over", lat, 45, 1, 2'd1, 4'd6, 0);
`endif

    run_req(b5, 7'd55, lat);
    chk_result("t_cross", lat, 45, 1, 2'd0, 4'd5, 0);

    run_req(b6, 7'd36, lat);
    chk_result("t_offctr", lat, 45, 0, 2'd0, 4'd1, 0);

    run_req(b1, 7'd100, lat);
    chk_result("t5_badpos", lat, 1, 0, 2'd0, 4'd0, 1);

    run_req(b1, 7'd35, lat);
    chk_result("t5_empty", lat, 1, 0, 2'd0, 4'd0, 1);

    // second start mid-scan must be ignored
    @(negedge clk);
    board = b1; pos = 7'd34; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    repeat (10) begin
      @(posedge clk);
      #1 lat++;
    end
    board = b2; pos = 7'd100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat++;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk_result("t6_ignore", lat, 45, 1, 2'd0, 4'd5, 0);

    // asynchronous reset in the middle of a scan
    @(negedge clk);
    board = b1; pos = 7'd34; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_len", 32'(run_len), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (60) begin
      @(posedge clk);
      #1 if (done) pulses++;
    end
    chk("t6_no_pulse", 32'(pulses), 0);

    run_req(b1, 7'd30, lat);
    chk_result("t6_after_rst", lat, 45, 1, 2'd0, 4'd5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
